// File: rtl/adc_burst_capture_if.sv
// AXI-Stream sample channel between adc_burst_capture and the acquisition DMA/FIFO.
// TUSER (first-beat marker) exists only when ADC_BURST_TIMESTAMP_EN is defined.
`timescale 1ns/1ps
interface adc_burst_capture_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
`ifdef ADC_BURST_TIMESTAMP_EN
    logic [0:0]  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
`else
    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
`endif
endinterface

// File: rtl/adc_burst_capture.sv
// Captures N ADC samples after a trigger rising edge and forwards them as one AXI-Stream packet.
// Optional ADC_BURST_TIMESTAMP_EN adds a trigger timestamp output and a first-beat TUSER flag.
`timescale 1ns/1ps
module adc_burst_capture #(
    parameter int ADC_WIDTH      = 14,
    parameter int CFG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic [ADC_WIDTH-1:0]      adc_data_i,
    input  logic [CFG_DATA_WIDTH-1:0] cfg_length_i,
    input  logic                      arm_i,
    input  logic                      trigger_i,
    adc_burst_capture_if.master       m_axis,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overflow_o
`ifdef ADC_BURST_TIMESTAMP_EN
    ,
    output logic [31:0]               trig_timestamp_o
`endif
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_DONE    = 3'd3;
    localparam logic [2:0] ST_CONT    = 3'd4;

    localparam int                      EXT_W   = 16 - ADC_WIDTH;
    localparam logic [CFG_DATA_WIDTH-1:0] CNT_ONE = {{(CFG_DATA_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]                state_q, state_d;
    logic [CFG_DATA_WIDTH-1:0] len_q, len_d;
    logic [CFG_DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic                      trig_q;
    logic [15:0]               tdata_q, tdata_d;
    logic                      tvalid_q, tvalid_d;
    logic                      tlast_q, tlast_d;
    logic                      ovf_q, ovf_d;
    logic                      busy_q, done_q;

    logic edge_s, cfg_zero_s, slot_s, last_s, load_s, ovf_clr_s;

    assign edge_s     = trigger_i & ~trig_q;
    assign cfg_zero_s = (cfg_length_i == {CFG_DATA_WIDTH{1'b0}});
    assign load_s     = slot_s & (~tvalid_q | m_axis.tready);
    assign ovf_clr_s  = arm_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // Burst sequencing: decides whether this cycle's ADC sample occupies a slot, and whether it is the last one.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        slot_s  = 1'b0;
        last_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_zero_s) begin
                    state_d = ST_CONT;
                end else if (arm_i) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (edge_s && cfg_zero_s) begin
                    state_d = ST_CONT;
                end else if (edge_s) begin
                    len_d   = cfg_length_i;
                    cnt_d   = CNT_ONE;
                    slot_s  = 1'b1;
                    last_s  = (cfg_length_i == CNT_ONE);
                    state_d = last_s ? ST_DONE : ST_CAPTURE;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                // A dropped slot still counts, keeping the burst time-aligned to the trigger.
                cnt_d   = cnt_q + CNT_ONE;
                slot_s  = 1'b1;
                last_s  = (cnt_d == len_q);
                state_d = last_s ? ST_DONE : ST_CAPTURE;
            end
            ST_DONE: begin
                if (cfg_zero_s) begin
                    state_d = ST_CONT;
                end else if (arm_i) begin
                    state_d = ST_ARMED;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_CONT: begin
                slot_s  = 1'b1;
                state_d = cfg_zero_s ? ST_CONT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ADC_BURST_TIMESTAMP_EN
    logic        first_s;
    logic [0:0]  tuser_q, tuser_d;
    logic [31:0] ts_cnt_q;
    logic [31:0] trig_ts_q;

    assign first_s = (state_q == ST_ARMED) & slot_s;
`endif

    // Single-stage output register: load when empty or draining, otherwise drop and flag overflow.
    always_comb begin
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
`ifdef ADC_BURST_TIMESTAMP_EN
        tuser_d  = tuser_q;
`endif
        if (load_s) begin
            tdata_d  = {{EXT_W{adc_data_i[ADC_WIDTH-1]}}, adc_data_i};
            tvalid_d = 1'b1;
            tlast_d  = last_s;
`ifdef ADC_BURST_TIMESTAMP_EN
            tuser_d  = first_s;
`endif
        end else if (slot_s) begin
            // Losing the final slot must still terminate the packet on the beat being held.
            tlast_d  = tlast_q | last_s;
        end else if (tvalid_q && m_axis.tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
`ifdef ADC_BURST_TIMESTAMP_EN
            tuser_d  = 1'b0;
`endif
        end else begin
            tvalid_d = tvalid_q;
        end

        if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else if (slot_s && !load_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            len_q    <= {CFG_DATA_WIDTH{1'b0}};
            cnt_q    <= {CFG_DATA_WIDTH{1'b0}};
            trig_q   <= 1'b0;
            tdata_q  <= 16'h0000;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            trig_q   <= trigger_i;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ovf_q    <= ovf_d;
            busy_q   <= (state_d == ST_ARMED) | (state_d == ST_CAPTURE);
            done_q   <= (state_d == ST_DONE);
        end
    end

`ifdef ADC_BURST_TIMESTAMP_EN
    // Free-running cycle counter, sampled when a burst starts.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            ts_cnt_q  <= 32'd0;
            trig_ts_q <= 32'd0;
            tuser_q   <= 1'b0;
        end else begin
            ts_cnt_q  <= ts_cnt_q + 32'd1;
            trig_ts_q <= first_s ? ts_cnt_q : trig_ts_q;
            tuser_q   <= tuser_d;
        end
    end

    assign m_axis.tuser     = tuser_q;
    assign trig_timestamp_o = trig_ts_q;
`endif

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_adc_burst_capture.sv
// Bench for adc_burst_capture: table of burst/backpressure cases feeding a beat scoreboard,
// plus hand sequences for continuous mode, back-to-back single-sample bursts and mid-burst reset.
`timescale 1ns/1ps
module tb_adc_burst_capture;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [13:0] adc_data;
    logic [31:0] cfg_length;
    logic        arm;
    logic        trigger;
    logic        busy, done, overflow;
`ifdef ADC_BURST_TIMESTAMP_EN
    logic [31:0] trig_ts;
`endif

    always #5 clk = ~clk;

    adc_burst_capture_if m_if();

    adc_burst_capture dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .adc_data_i   (adc_data),
        .cfg_length_i (cfg_length),
        .arm_i        (arm),
        .trigger_i    (trigger),
        .m_axis       (m_if),
        .busy_o       (busy),
        .done_o       (done),
        .overflow_o   (overflow)
`ifdef ADC_BURST_TIMESTAMP_EN
        ,
        .trig_timestamp_o (trig_ts)
`endif
    );

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct {
        int          len;
        int          stall_from;
        int          stall_len;
        logic [31:0] keep;
        logic        exp_ovf;
    } vec_t;

    beat_t sb_q[$];
    vec_t  vecs[5];
    int    n_chk   = 0;
    int    n_pass  = 0;
    int    cyc     = 0;
    int    rst_cyc = 0;
    bit    sb_en   = 1'b1;

    function automatic logic [13:0] adc_f(input int c);
        logic [31:0] v;
        v = c * 37 + 5;
        return v[13:0];
    endfunction

    function automatic logic [15:0] sext(input logic [13:0] a);
        return {{2{a[13]}}, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_beat(input int c, input logic last, input logic user);
        beat_t b;
        b.data = sext(adc_f(c));
        b.last = last;
        b.user = user;
        sb_q.push_back(b);
    endtask

    // One clock: drive the ramp sample, score an accepted beat, advance past the edge.
    task automatic tick();
        beat_t e;
        adc_data = adc_f(cyc);
        if (sb_en && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_beat: got tdata %0h tlast %0b, expected no beat (cycle %0d)",
                         m_if.tdata, m_if.tlast, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("tdata", {16'h0, m_if.tdata}, {16'h0, e.data});
                chk("tlast", {31'h0, m_if.tlast}, {31'h0, e.last});
`ifdef ADC_BURST_TIMESTAMP_EN
                chk("tuser", {31'h0, m_if.tuser}, {31'h0, e.user});
`endif
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int t0;
        int hi;

        vecs[0] = '{len: 4, stall_from: 0, stall_len: 0, keep: 32'h0000_000F, exp_ovf: 1'b0};
        vecs[1] = '{len: 8, stall_from: 3, stall_len: 3, keep: 32'h0000_00C7, exp_ovf: 1'b1};
        vecs[2] = '{len: 4, stall_from: 3, stall_len: 2, keep: 32'h0000_0007, exp_ovf: 1'b1};
        vecs[3] = '{len: 6, stall_from: 1, stall_len: 1, keep: 32'h0000_003D, exp_ovf: 1'b1};
        vecs[4] = '{len: 3, stall_from: 4, stall_len: 2, keep: 32'h0000_0007, exp_ovf: 1'b0};

        aresetn     = 1'b0;
        cfg_length  = 32'd4;
        arm         = 1'b0;
        trigger     = 1'b0;
        m_if.tready = 1'b1;
        adc_data    = 14'd0;
        #1;
        repeat (3) tick();
        rst_cyc = cyc - 1;
        aresetn = 1'b1;

        chk("rst_tvalid", {31'h0, m_if.tvalid}, 32'd0);
        chk("rst_tlast", {31'h0, m_if.tlast}, 32'd0);
        chk("rst_tdata", {16'h0, m_if.tdata}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_overflow", {31'h0, overflow}, 32'd0);

        foreach (vecs[v]) begin
            cfg_length  = vecs[v].len;
            arm         = 1'b1;
            trigger     = 1'b0;
            m_if.tready = 1'b1;
            repeat (3) tick();
            chk("armed_busy", {31'h0, busy}, 32'd1);
            chk("arm_clears_overflow", {31'h0, overflow}, 32'd0);

            arm     = 1'b0;
            trigger = 1'b1;
            t0      = cyc;
            hi      = 0;
            for (int k = 0; k < vecs[v].len; k++) if (vecs[v].keep[k]) hi = k;
            for (int k = 0; k < vecs[v].len; k++)
                if (vecs[v].keep[k]) push_beat(t0 + k, (k == hi), (k == 0));

            for (int k = 0; k < vecs[v].len + 8; k++) begin
                m_if.tready = !(k >= vecs[v].stall_from && k < vecs[v].stall_from + vecs[v].stall_len);
                if (k == 2) trigger = 1'b0;
                tick();
            end
            chk("burst_all_beats_seen", sb_q.size(), 32'd0);
            chk("burst_done", {31'h0, done}, 32'd1);
            chk("burst_busy", {31'h0, busy}, 32'd0);
            chk("burst_overflow", {31'h0, overflow}, {31'h0, vecs[v].exp_ovf});
            chk("burst_idle_out", {31'h0, m_if.tvalid}, 32'd0);
`ifdef ADC_BURST_TIMESTAMP_EN
            chk("trig_timestamp", trig_ts, t0 - rst_cyc - 1);
`endif
            sb_q.delete();
        end

        // Continuous pass-through: output is the ADC sample one cycle late.
        sb_en       = 1'b0;
        cfg_length  = 32'd0;
        m_if.tready = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 8; k++) begin
            chk("cont_tdata", {16'h0, m_if.tdata}, {16'h0, sext(adc_f(cyc - 1))});
            chk("cont_tvalid", {31'h0, m_if.tvalid}, 32'd1);
            chk("cont_tlast", {31'h0, m_if.tlast}, 32'd0);
            chk("cont_busy", {31'h0, busy}, 32'd0);
            tick();
        end
        cfg_length = 32'd5;
        repeat (3) tick();
        chk("cont_exit_tvalid", {31'h0, m_if.tvalid}, 32'd0);
        sb_en = 1'b1;

        // N=1 with arm held: one tlast beat per edge, DONE lasts a single cycle.
        cfg_length = 32'd1;
        arm        = 1'b1;
        repeat (3) tick();
        for (int e = 0; e < 3; e++) begin
            trigger = 1'b1;
            push_beat(cyc, 1'b1, 1'b1);
            tick();
            trigger = 1'b0;
            chk("n1_done", {31'h0, done}, 32'd1);
            chk("n1_busy_low", {31'h0, busy}, 32'd0);
            tick();
            chk("n1_rearmed", {31'h0, busy}, 32'd1);
            chk("n1_done_low", {31'h0, done}, 32'd0);
            repeat (3) tick();
        end
        chk("n1_all_beats_seen", sb_q.size(), 32'd0);
        arm = 1'b0;

        // Reset during beat 3 of a 10-sample burst aborts it without tlast.
        aresetn = 1'b0;
        tick();
        rst_cyc    = cyc - 1;
        aresetn    = 1'b1;
        cfg_length = 32'd10;
        arm        = 1'b1;
        repeat (2) tick();
        arm     = 1'b0;
        trigger = 1'b1;
        t0      = cyc;
        for (int k = 0; k < 3; k++) push_beat(t0 + k, 1'b0, (k == 0));
        tick();
        trigger = 1'b0;
        repeat (2) tick();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("midrst_tvalid", {31'h0, m_if.tvalid}, 32'd0);
        chk("midrst_tlast", {31'h0, m_if.tlast}, 32'd0);
        chk("midrst_busy", {31'h0, busy}, 32'd0);
        chk("midrst_done", {31'h0, done}, 32'd0);
        chk("midrst_beats_seen", sb_q.size(), 32'd0);
        for (int k = 0; k < 12; k++) begin
            trigger = (k % 4) >= 2;
            tick();
        end
        chk("noarm_busy", {31'h0, busy}, 32'd0);
        chk("noarm_tvalid", {31'h0, m_if.tvalid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
